// File: rtl/mac_pkg.sv
// Shared types and constants for the dot-product sequencer and its tag pipe.
// MAC_LAT and MAX_LEN are set here because the tag lane width is derived from MAC_LAT.
package mac_pkg;

  localparam int unsigned MAC_LAT = 3;    // legal range 1..8
  localparam int unsigned MAX_LEN = 256;
  localparam int unsigned DW      = 8;
  localparam int unsigned AW      = 32;
  localparam int unsigned LANE_W  = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;
  localparam int unsigned LEN_W   = $clog2(MAX_LEN + 1);

  typedef logic signed [DW-1:0] op_t;
  typedef logic signed [AW-1:0] acc_t;
  typedef logic [LANE_W-1:0]    lane_t;

  typedef enum logic [2:0] {StIdle, StStream, StDrain, StReduce, StOut} dot_state_e;

  typedef struct packed {
    logic  valid;
    lane_t lane;
  } tag_t;

  function automatic lane_t next_lane(lane_t l);
    return (l == lane_t'(MAC_LAT - 1)) ? '0 : l + lane_t'(1);
  endfunction

endpackage

// File: rtl/mac_tag_pipe.sv
// Tag shift register aligned with mac_pipeline, plus per-lane busy tracking.
// A lane is busy from its issue handshake until its result returns.
module mac_tag_pipe
  import mac_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               issue,
  input  lane_t              issue_lane,
  input  logic               mac_in_valid,
  input  lane_t              mac_lane,
  input  logic               mac_out_valid,
  output logic               ret_valid,
  output lane_t              ret_lane,
  output logic [MAC_LAT-1:0] busy,
  output logic               drained
);

  tag_t               pipe_q [MAC_LAT];
  tag_t               head;
  logic [MAC_LAT-1:0] busy_q, busy_d, ret_mask, set_mask;
  logic [3:0]         settle_q;

  assign head      = pipe_q[MAC_LAT-1];
  assign ret_valid = mac_out_valid && head.valid;
  assign ret_lane  = head.lane;
  assign busy      = busy_q;

  always_comb begin
    ret_mask = '0;
    set_mask = '0;
    if (ret_valid) ret_mask[ret_lane] = 1'b1;
    if (issue)     set_mask[issue_lane] = 1'b1;
    busy_d  = (busy_q & ~ret_mask) | set_mask;
    drained = ((busy_q & ~ret_mask) == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MAC_LAT; i++) pipe_q[i] <= '0;
      busy_q   <= '0;
      settle_q <= '0;
    end else begin
      pipe_q[0] <= '{valid: mac_in_valid, lane: mac_lane};
      for (int i = 1; i < MAC_LAT; i++) pipe_q[i] <= pipe_q[i-1];
      busy_q <= busy_d;
      if (settle_q != 4'(MAC_LAT)) settle_q <= settle_q + 4'd1;
    end
  end

  // Results issued before a reset may still emerge for MAC_LAT cycles; those are expected.
  a_no_orphan_result : assert property (@(posedge clk)
    disable iff (rst || settle_q != 4'(MAC_LAT)) !(mac_out_valid && !head.valid));

endmodule

// File: rtl/mac_dot_sequencer.sv
// Issues int8 operand pairs to mac_pipeline across MAC_LAT interleaved partial sums,
// then reduces them to one result. Define MAC_DOT_SAT_EN for a saturating reduce and sat_flag.
module mac_dot_sequencer
  import mac_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [DW-1:0]    op_a,
  input  logic [DW-1:0]    op_b,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [AW-1:0]    res_data,
  output logic             mac_in_valid,
  output logic [DW-1:0]    mac_a,
  output logic [DW-1:0]    mac_b,
  output logic [AW-1:0]    mac_acc,
  input  logic             mac_out_valid,
  input  logic [AW-1:0]    mac_y
`ifdef MAC_DOT_SAT_EN
  ,
  output logic             sat_flag
`endif
);

  dot_state_e         state_q, state_d;
  logic [LEN_W-1:0]   len_q, len_d, issued_q, issued_d;
  lane_t              lane_q, lane_d, red_q, red_d, mlane_q, mlane_d;
  acc_t               ps_q [MAC_LAT];
  acc_t               ps_d [MAC_LAT];
  acc_t               sum_q, sum_d, res_q, res_d, acc_q, acc_d;
  op_t                a_q, a_d, b_q, b_d;
  logic               miv_q, miv_d;
  logic               issue, ret_valid, lane_ret, drained;
  lane_t              ret_lane;
  logic [MAC_LAT-1:0] busy;
`ifdef MAC_DOT_SAT_EN
  logic               sat_q, sat_d;
  logic [AW:0]        wide;
`endif

  mac_tag_pipe u_tag_pipe (
    .clk          (clk),
    .rst          (rst),
    .issue        (issue),
    .issue_lane   (lane_q),
    .mac_in_valid (miv_q),
    .mac_lane     (mlane_q),
    .mac_out_valid(mac_out_valid),
    .ret_valid    (ret_valid),
    .ret_lane     (ret_lane),
    .busy         (busy),
    .drained      (drained)
  );

  assign lane_ret = ret_valid && (ret_lane == lane_q);

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    issued_d = issued_q;
    lane_d   = lane_q;
    red_d    = red_q;
    ps_d     = ps_q;
    sum_d    = sum_q;
    res_d    = res_q;
    miv_d    = 1'b0;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    mlane_d  = mlane_q;
    issue    = 1'b0;
    op_ready = 1'b0;
    cmd_ready = (state_q == StIdle);
    res_valid = (state_q == StOut);
`ifdef MAC_DOT_SAT_EN
    sat_d = sat_q;
    wide  = '0;
`endif
    if (ret_valid) ps_d[ret_lane] = mac_y;

    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          len_d    = cmd_len;
          ps_d     = '{default: '0};
          lane_d   = '0;
          issued_d = '0;
`ifdef MAC_DOT_SAT_EN
          sat_d = 1'b0;
`endif
          if (cmd_len == '0) begin
            res_d   = '0;
            state_d = StOut;
          end else begin
            state_d = StStream;
          end
        end
      end
      StStream: begin
        op_ready = !busy[lane_q] || lane_ret;
        if (op_valid && op_ready) begin
          issue   = 1'b1;
          miv_d   = 1'b1;
          a_d     = op_a;
          b_d     = op_b;
          // Bypass the lane's partial when it lands in the same cycle.
          acc_d   = lane_ret ? mac_y : ps_q[lane_q];
          mlane_d = lane_q;
          lane_d  = next_lane(lane_q);
          issued_d = issued_q + 1'b1;
          if (issued_d == len_q) state_d = StDrain;
        end
      end
      StDrain: begin
        if (drained) begin
          sum_d   = '0;
          red_d   = '0;
          state_d = StReduce;
        end
      end
      StReduce: begin
`ifdef MAC_DOT_SAT_EN
        wide = {sum_q[AW-1], sum_q} + {ps_q[red_q][AW-1], ps_q[red_q]};
        if (wide[AW] != wide[AW-1]) begin
          sum_d = wide[AW] ? {1'b1, {(AW-1){1'b0}}} : {1'b0, {(AW-1){1'b1}}};
          sat_d = 1'b1;
        end else begin
          sum_d = wide[AW-1:0];
        end
`else
        sum_d = sum_q + ps_q[red_q];
`endif
        red_d = next_lane(red_q);
        if (red_q == lane_t'(MAC_LAT - 1)) begin
          res_d   = sum_d;
          state_d = StOut;
        end
      end
      StOut: begin
        if (res_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      len_q    <= '0;
      issued_q <= '0;
      lane_q   <= '0;
      red_q    <= '0;
      for (int i = 0; i < MAC_LAT; i++) ps_q[i] <= '0;
      sum_q    <= '0;
      res_q    <= '0;
      miv_q    <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      mlane_q  <= '0;
`ifdef MAC_DOT_SAT_EN
      sat_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      issued_q <= issued_d;
      lane_q   <= lane_d;
      red_q    <= red_d;
      ps_q     <= ps_d;
      sum_q    <= sum_d;
      res_q    <= res_d;
      miv_q    <= miv_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      mlane_q  <= mlane_d;
`ifdef MAC_DOT_SAT_EN
      sat_q    <= sat_d;
`endif
    end
  end

  assign mac_in_valid = miv_q;
  assign mac_a        = a_q;
  assign mac_b        = b_q;
  assign mac_acc      = acc_q;
  assign res_data     = res_q;
`ifdef MAC_DOT_SAT_EN
  assign sat_flag     = sat_q;
`endif

endmodule

// File: tb/tb_mac_dot_sequencer.sv
// Bench for mac_dot_sequencer: behavioural mac_pipeline (latency 3), vector table, scoreboard.
module tb_mac_dot_sequencer;

  localparam int L = 3;

  logic               clk = 1'b0;
  logic               rst;
  logic               cmd_valid, cmd_ready;
  logic [8:0]         cmd_len;
  logic               op_valid, op_ready;
  logic signed [7:0]  op_a, op_b;
  logic               res_valid, res_ready;
  logic signed [31:0] res_data;
  logic               mac_in_valid;
  logic signed [7:0]  mac_a, mac_b;
  logic signed [31:0] mac_acc;
  logic               mac_out_valid;
  logic signed [31:0] mac_y;
`ifdef MAC_DOT_SAT_EN
  logic               sat_flag;
`endif

  always #5 clk = ~clk;

  mac_dot_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_len      (cmd_len),
    .op_valid     (op_valid),
    .op_ready     (op_ready),
    .op_a         (op_a),
    .op_b         (op_b),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_data     (res_data),
    .mac_in_valid (mac_in_valid),
    .mac_a        (mac_a),
    .mac_b        (mac_b),
    .mac_acc      (mac_acc),
    .mac_out_valid(mac_out_valid),
    .mac_y        (mac_y)
`ifdef MAC_DOT_SAT_EN
    ,
    .sat_flag     (sat_flag)
`endif
  );

  // mac_pipeline model: y = acc + a*b, L cycles later; deliberately not reset.
  bit mv_q [L];
  int my_q [L];
  always @(posedge clk) begin
    mv_q[0] <= mac_in_valid;
    my_q[0] <= mac_acc + mac_a * mac_b;
    for (int i = 1; i < L; i++) begin
      mv_q[i] <= mv_q[i-1];
      my_q[i] <= my_q[i-1];
    end
  end
  assign mac_out_valid = mv_q[L-1];
  assign mac_y         = my_q[L-1];

  int tests = 0, fails = 0, cyc = 0;
  int exp_q[$];
  int lane_exp [L];
  int lane_idx, mac_cnt, mac_first, mac_last;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Output monitor: result scoreboard and per-lane running partial check on every issue.
  initial forever begin
    @(negedge clk);
    if (!rst && res_valid && res_ready) begin
      if (exp_q.size() == 0) check("sb_underflow", 1, 0);
      else check("res_data", res_data, exp_q.pop_front());
    end
    if (!rst && mac_in_valid) begin
      check("mac_acc", mac_acc, lane_exp[lane_idx]);
      lane_exp[lane_idx] += int'(mac_a) * int'(mac_b);
      lane_idx = (lane_idx + 1) % L;
      if (mac_cnt == 0) mac_first = cyc;
      mac_last = cyc;
      mac_cnt++;
    end
  end

  task automatic start_cmd(input int len, input bit keep, output int hs_cyc);
    bit done = 0;
    int t = 0;
    hs_cyc = 0;
    cmd_valid = 1'b1;
    cmd_len = 9'(len);
    while (!done && t < 100) begin
      @(negedge clk);
      if (cmd_ready) begin
        done = 1;
        hs_cyc = cyc;
        lane_idx = 0;
        mac_cnt = 0;
        for (int i = 0; i < L; i++) lane_exp[i] = 0;
      end
      @(posedge clk);
      #1;
      t++;
    end
    if (!done) check("cmd_timeout", 0, 1);
    if (keep) cmd_len = 9'd0;
    else cmd_valid = 1'b0;
  endtask

  task automatic send_ops(input int len, input int ab, input int as, input int bb, input int bs,
                          input bit gap);
    int i = 0, t = 0;
    bit tog = 0;
    while (i < len && t < 3000) begin
      op_a = 8'(ab + i * as);
      op_b = 8'(bb + i * bs);
      op_valid = !(gap && tog);
      tog = !tog;
      @(negedge clk);
      if (op_valid && op_ready) i++;
      @(posedge clk);
      #1;
      t++;
    end
    op_valid = 1'b0;
    if (i < len) check("op_timeout", i, len);
  endtask

  task automatic wait_result(input int exp, input int hold, output int first);
    int t = 0;
    res_ready = 1'b0;
    first = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!res_valid && t < 3000);
    if (!res_valid) begin
      check("res_timeout", 0, 1);
      return;
    end
    first = cyc;
    for (int h = 0; h < hold; h++) begin
      check("hold_valid", res_valid, 1);
      check("hold_data", res_data, exp);
      check("hold_cmd_ready", cmd_ready, 0);
      @(negedge clk);
    end
    @(posedge clk);
    #1 res_ready = 1'b1;
    @(posedge clk);
    #1 res_ready = 1'b0;
    @(negedge clk);
    check("post_res_valid", res_valid, 0);
    check("post_cmd_ready", cmd_ready, 1);
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    int len; int ab; int as; int bb; int bs; bit gap; int hold; int exp;
  } vec_t;

  vec_t vecs [8];
  int   pa [3];
  int   pb [3];

  initial begin
    int hs, first, n;

    vecs[0] = '{len: 0,   ab: 0,    as: 0,  bb: 0,    bs: 0,  gap: 0, hold: 0,  exp: 0};
    vecs[1] = '{len: 7,   ab: 1,    as: 1,  bb: 2,    bs: 0,  gap: 1, hold: 0,  exp: 56};
    vecs[2] = '{len: 4,   ab: 127,  as: 0,  bb: 127,  bs: 0,  gap: 0, hold: 10, exp: 64516};
    vecs[3] = '{len: 256, ab: 127,  as: 0,  bb: 127,  bs: 0,  gap: 0, hold: 0,  exp: 4129024};
    vecs[4] = '{len: 2,   ab: -128, as: 0,  bb: -128, bs: 0,  gap: 0, hold: 0,  exp: 32768};
    vecs[5] = '{len: 1,   ab: 2,    as: 0,  bb: 3,    bs: 0,  gap: 0, hold: 0,  exp: 6};
    vecs[6] = '{len: 6,   ab: -3,   as: 1,  bb: 5,    bs: -1, gap: 0, hold: 2,  exp: -25};
    vecs[7] = '{len: 5,   ab: 10,   as: -4, bb: -7,   bs: 3,  gap: 1, hold: 0,  exp: -130};
    pa = '{3, -2, 8};
    pb = '{4, 7, 8};

    rst = 1'b1; cmd_valid = 1'b0; cmd_len = '0; op_valid = 1'b0;
    op_a = '0; op_b = '0; res_ready = 1'b0;
    lane_idx = 0; mac_cnt = 0; mac_first = 0; mac_last = 0;
    for (int i = 0; i < L; i++) lane_exp[i] = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_op_ready", op_ready, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_data", res_data, 0);
    check("rst_mac_in_valid", mac_in_valid, 0);
    check("rst_mac_a", mac_a, 0);
    check("rst_mac_b", mac_b, 0);
    check("rst_mac_acc", mac_acc, 0);
    @(posedge clk);
    #1;

    // N=3, continuous operands, cmd_valid held high (must be ignored outside IDLE).
    exp_q.push_back(62);
    start_cmd(3, 1, hs);
    for (int i = 0; i < 3; i++) begin
      op_a = 8'(pa[i]);
      op_b = 8'(pb[i]);
      op_valid = 1'b1;
      @(negedge clk);
      check("n3_op_ready", op_ready, 1);
      check("n3_cmd_ready", cmd_ready, 0);
      @(posedge clk);
      #1;
    end
    op_valid = 1'b0;
    cmd_valid = 1'b0;
    wait_result(62, 0, first);
    check("n3_latency", first - hs, 3 + 2 * L + 2);
    check("n3_mac_count", mac_cnt, 3);
    check("n3_mac_first", mac_first - hs, 2);
    check("n3_mac_span", mac_last - mac_first, 2);

    foreach (vecs[k]) begin
      exp_q.push_back(vecs[k].exp);
      start_cmd(vecs[k].len, 0, hs);
      send_ops(vecs[k].len, vecs[k].ab, vecs[k].as, vecs[k].bb, vecs[k].bs, vecs[k].gap);
      wait_result(vecs[k].exp, vecs[k].hold, first);
      check("vec_mac_count", mac_cnt, vecs[k].len);
      if (vecs[k].len == 0) check("n0_latency", first - hs, 1);
`ifdef MAC_DOT_SAT_EN
      check("sat_flag", sat_flag, 0);
`endif
    end

    // Reset in the middle of an N=5 stream, then a fresh N=1 command.
    start_cmd(5, 0, hs);
    n = 0;
    for (int t = 0; t < 50 && n < 3; t++) begin
      op_a = 8'(n + 1);
      op_b = 8'd9;
      op_valid = 1'b1;
      @(negedge clk);
      if (op_ready) n++;
      @(posedge clk);
      #1;
    end
    check("mid_issued", n, 3);
    op_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("mid_rst_cmd_ready", cmd_ready, 1);
    check("mid_rst_op_ready", op_ready, 0);
    check("mid_rst_res_valid", res_valid, 0);
    check("mid_rst_res_data", res_data, 0);
    check("mid_rst_mac_in_valid", mac_in_valid, 0);
    check("mid_rst_mac_acc", mac_acc, 0);
    @(posedge clk);
    #1;
    exp_q.push_back(6);
    start_cmd(1, 0, hs);
    send_ops(1, 2, 0, 3, 0, 0);
    wait_result(6, 0, first);
    check("post_rst_mac_count", mac_cnt, 1);

    check("sb_leftover", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
